cmd_frame_parser: RTL and testbench
===================================

Name: cmd_frame_parser

Overview:
- Receive-side counterpart of the response frame builder in the UART-AXI4 bridge.
- Pops host-to-device command bytes from the UART RX FIFO, hunts for SOF, and parses CMD, ADDR and write payload.
- Checks CRC-8 and the inter-byte timeout, then presents one decoded command to the bridge control FSM through a valid/consumed handshake.

Parameters:
- SOF_HOST_TO_DEVICE, 8'hA5, start-of-frame byte expected from the host.
- TIMEOUT_CYCLES, 100000, idle clock cycles tolerated between bytes inside a frame.
- MAX_DATA_BYTES, 64, payload buffer depth. Fixed at 64; frame_data is sized from it.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_fifo_data  in  8  RX FIFO head byte (first-word-fall-through), valid when !rx_fifo_empty
- rx_fifo_empty  in  1  RX FIFO empty
- rx_fifo_rd_en  out  1  pop strobe; asserted only when !rx_fifo_empty
- frame_valid  out  1  decoded frame available; held until frame_consumed
- frame_status  out  8  0x00 OK, 0x01 CRC error, 0x02 bad CMD, 0x03 timeout
- frame_cmd  out  8  received CMD byte
- frame_addr  out  32  received address, little-endian assembled
- frame_data  out  8 x [0:63]  write payload, byte 0 first
- frame_data_count  out  7  payload bytes received (0..64; 0 for reads and errors)
- frame_consumed  in  1  one-cycle acknowledge from the bridge
- parser_busy  out  1  high whenever state != IDLE
- stat_frames_ok, stat_crc_err, stat_timeout, stat_discard  out  16 each  statistics counters (see Optional Feature)

Behaviour:
- Reset: state IDLE; all outputs 0; payload array 0; CRC 0; counters 0. Reset mid-frame drops the partial frame.
- CMD fields:
  - CMD[7]: 1 = read, 0 = write.
  - CMD[5:4]: size; 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = invalid.
  - CMD[3:0]: beats - 1.
  - Write payload bytes = (CMD[3:0]+1) << CMD[5:4]; maximum 64. Reads carry no payload.
- CRC-8: polynomial 0x07, init 0x00, MSB-first. Covers CMD, ADDR and DATA; excludes SOF. Updated on each popped byte.
- Pop rule: rx_fifo_rd_en = !rx_fifo_empty in IDLE, CMD, ADDR, DATA and CRC states. Forced 0 in HOLD. Exactly one byte is consumed per asserted cycle.
- FSM:
  - IDLE: on pop, byte == SOF -> CMD with CRC cleared. Any other byte is discarded and stat_discard increments.
  - CMD: on pop, latch CMD and update CRC. Size 11 -> HOLD with status 0x02. Otherwise -> ADDR with byte index 0.
  - ADDR: 4 pops, byte i lands in frame_addr[8i+7:8i]. After the 4th byte: write -> DATA; read -> CRC.
  - DATA: each pop writes frame_data[idx] and increments idx. When idx reaches the computed byte count -> CRC.
  - CRC: on pop, compare with running CRC. Match -> status 0x00; mismatch -> 0x01 and frame_data_count forced 0. Then -> HOLD.
  - HOLD: frame_valid = 1 and outputs stable. frame_consumed -> IDLE in the next cycle. frame_consumed outside HOLD is ignored.
- Timeout:
  - Counter runs in CMD/ADDR/DATA/CRC while rx_fifo_empty, and clears on every pop.
  - Reaching TIMEOUT_CYCLES -> HOLD with status 0x03 and count 0.
  - No timeout applies in IDLE or HOLD.
- Latency: frame_valid rises on the cycle after the CRC byte pop.
- Back-to-back frames: bytes stay in the RX FIFO while in HOLD; no data is lost. Minimum one IDLE cycle between frames.
- After an error, parsing resumes by SOF hunt; remaining bytes of the bad frame are discarded.

Optional Feature:
- Macro: FRAME_PARSER_STATS_EN.
- Defined: the four stat_* counters increment (frame OK, CRC error, timeout, discarded IDLE byte). They saturate at 0xFFFF and clear on rst.
- Undefined: stat_* ports remain but are tied to 0; no counter logic is synthesized.

Test Plan:
- Read frame: A5 80 00 00 00 00 97 -> frame_valid, status 0x00, cmd 0x80, addr 0x00000000, count 0. Hold frame_consumed low 10 cycles -> outputs stable, rd_en 0.
- Word write: A5 20 10 00 00 40 EF BE AD DE + correct CRC -> status 0x00, addr 0x40000010, data[0..3] = EF BE AD DE, count 4.
- Same write with CRC byte XOR 0x01 -> status 0x01, count 0. A following valid frame parses OK.
- Leading garbage 00 FF 5A, then a valid frame -> frame parsed OK, stat_discard = 3 (stats enabled).
- Invalid CMD: A5 30 ... -> status 0x02 immediately after CMD; remaining bytes discarded until the next A5.
- Timeout and reset: A5 80 00, then no bytes for TIMEOUT_CYCLES -> status 0x03. Separately, rst asserted during DATA -> IDLE, frame_valid 0, next frame OK.

Source files
------------

// File: rtl/cmd_frame_parser.sv
// Host-to-device command frame parser: SOF hunt, CMD/ADDR/DATA capture, CRC-8 and inter-byte timeout.
// Define FRAME_PARSER_STATS_EN to build the saturating stat_* counters; otherwise they read as 0.
module cmd_frame_parser #(
  parameter logic [7:0]  SOF_HOST_TO_DEVICE = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES     = 100000,
  parameter int unsigned MAX_DATA_BYTES     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_fifo_data,
  input  logic        rx_fifo_empty,
  output logic        rx_fifo_rd_en,
  output logic        frame_valid,
  output logic [7:0]  frame_status,
  output logic [7:0]  frame_cmd,
  output logic [31:0] frame_addr,
  output logic [7:0]  frame_data [0:MAX_DATA_BYTES-1],
  output logic [6:0]  frame_data_count,
  input  logic        frame_consumed,
  output logic        parser_busy,
  output logic [15:0] stat_frames_ok,
  output logic [15:0] stat_crc_err,
  output logic [15:0] stat_timeout,
  output logic [15:0] stat_discard
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned IDX_W = $clog2(MAX_DATA_BYTES);

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_CRC_ERR = 8'h01;
  localparam logic [7:0] ST_BAD_CMD = 8'h02;
  localparam logic [7:0] ST_TIMEOUT = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_CRC, S_HOLD
  } state_t;

  state_t          state;
  logic [7:0]      crc;
  logic [1:0]      addr_idx;
  logic [6:0]      data_idx;
  logic [6:0]      data_len;
  logic [TO_W-1:0] to_cnt;
  logic            pop;
  logic            in_frame;
  logic            timeout_hit;

  function automatic logic [7:0] crc8_next(input logic [7:0] crc_in, input logic [7:0] din);
    logic [7:0] c;
    c = crc_in ^ din;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // Pop is combinational so a byte leaves the FIFO in the same cycle it is parsed.
  assign pop           = !rst && !rx_fifo_empty && (state != S_HOLD);
  assign rx_fifo_rd_en = pop;
  assign parser_busy   = (state != S_IDLE);
  assign in_frame      = state inside {S_CMD, S_ADDR, S_DATA, S_CRC};
  assign timeout_hit   = rx_fifo_empty && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign data_len      = ({3'b000, frame_cmd[3:0]} + 7'd1) << frame_cmd[5:4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      crc              <= '0;
      addr_idx         <= '0;
      data_idx         <= '0;
      to_cnt           <= '0;
      frame_valid      <= 1'b0;
      frame_status     <= '0;
      frame_cmd        <= '0;
      frame_addr       <= '0;
      frame_data_count <= '0;
      // NOTE: the payload array is reset like any other register because its reset value is visible on frame_data.
      for (int i = 0; i < MAX_DATA_BYTES; i++) frame_data[i] <= '0;
    end else if (in_frame && timeout_hit) begin
      state            <= S_HOLD;
      frame_valid      <= 1'b1;
      frame_status     <= ST_TIMEOUT;
      frame_data_count <= '0;
      to_cnt           <= '0;
    end else begin
      // NOTE: every register here uses <= so all branches see the pre-edge values of state, crc and indices.
      if (in_frame) to_cnt <= pop ? '0 : to_cnt + TO_W'(1);
      case (state)
        S_IDLE: if (pop && rx_fifo_data == SOF_HOST_TO_DEVICE) begin
          state            <= S_CMD;
          crc              <= '0;
          to_cnt           <= '0;
          frame_status     <= ST_OK;
          frame_cmd        <= '0;
          frame_addr       <= '0;
          frame_data_count <= '0;
        end
        S_CMD: if (pop) begin
          frame_cmd <= rx_fifo_data;
          crc       <= crc8_next(crc, rx_fifo_data);
          if (rx_fifo_data[5:4] == 2'b11) begin
            state        <= S_HOLD;
            frame_valid  <= 1'b1;
            frame_status <= ST_BAD_CMD;
          end else begin
            state    <= S_ADDR;
            addr_idx <= '0;
          end
        end
        S_ADDR: if (pop) begin
          frame_addr[{addr_idx, 3'b000} +: 8] <= rx_fifo_data;
          crc      <= crc8_next(crc, rx_fifo_data);
          addr_idx <= addr_idx + 2'd1;
          data_idx <= '0;
          if (addr_idx == 2'd3) state <= frame_cmd[7] ? S_CRC : S_DATA;
        end
        S_DATA: if (pop) begin
          frame_data[data_idx[IDX_W-1:0]] <= rx_fifo_data;
          crc      <= crc8_next(crc, rx_fifo_data);
          data_idx <= data_idx + 7'd1;
          if (data_idx + 7'd1 == data_len) state <= S_CRC;
        end
        S_CRC: if (pop) begin
          state       <= S_HOLD;
          frame_valid <= 1'b1;
          if (rx_fifo_data == crc) begin
            frame_status     <= ST_OK;
            frame_data_count <= frame_cmd[7] ? 7'd0 : data_len;
          end else begin
            frame_status     <= ST_CRC_ERR;
            frame_data_count <= '0;
          end
        end
        S_HOLD: if (frame_consumed) begin
          state       <= S_IDLE;
          frame_valid <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FRAME_PARSER_STATS_EN
  logic ev_ok, ev_crc, ev_to, ev_disc;

  assign ev_disc = (state == S_IDLE) && pop && (rx_fifo_data != SOF_HOST_TO_DEVICE);
  assign ev_ok   = (state == S_CRC) && pop && (rx_fifo_data == crc);
  assign ev_crc  = (state == S_CRC) && pop && (rx_fifo_data != crc);
  assign ev_to   = in_frame && timeout_hit;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic ev);
    return (ev && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames_ok <= '0;
      stat_crc_err   <= '0;
      stat_timeout   <= '0;
      stat_discard   <= '0;
    end else begin
      stat_frames_ok <= sat_inc(stat_frames_ok, ev_ok);
      stat_crc_err   <= sat_inc(stat_crc_err, ev_crc);
      stat_timeout   <= sat_inc(stat_timeout, ev_to);
      stat_discard   <= sat_inc(stat_discard, ev_disc);
    end
  end
`else
  assign stat_frames_ok = '0;
  assign stat_crc_err   = '0;
  assign stat_timeout   = '0;
  assign stat_discard   = '0;
`endif

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Self-checking bench for cmd_frame_parser: directed frames from the test plan plus randomized frames
// checked against a byte-stream reference model (CRC by polynomial division).
module tb_cmd_frame_parser;

  localparam int TIMEOUT = 300;
`ifdef FRAME_PARSER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_fifo_data = 8'h00;
  logic        rx_fifo_empty = 1'b1;
  logic        rx_fifo_rd_en;
  logic        frame_valid;
  logic [7:0]  frame_status;
  logic [7:0]  frame_cmd;
  logic [31:0] frame_addr;
  logic [7:0]  frame_data [0:63];
  logic [6:0]  frame_data_count;
  logic        frame_consumed = 1'b0;
  logic        parser_busy;
  logic [15:0] stat_frames_ok, stat_crc_err, stat_timeout, stat_discard;

  cmd_frame_parser #(
    .SOF_HOST_TO_DEVICE(8'hA5),
    .TIMEOUT_CYCLES    (TIMEOUT),
    .MAX_DATA_BYTES    (64)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_fifo_data    (rx_fifo_data),
    .rx_fifo_empty   (rx_fifo_empty),
    .rx_fifo_rd_en   (rx_fifo_rd_en),
    .frame_valid     (frame_valid),
    .frame_status    (frame_status),
    .frame_cmd       (frame_cmd),
    .frame_addr      (frame_addr),
    .frame_data      (frame_data),
    .frame_data_count(frame_data_count),
    .frame_consumed  (frame_consumed),
    .parser_busy     (parser_busy),
    .stat_frames_ok  (stat_frames_ok),
    .stat_crc_err    (stat_crc_err),
    .stat_timeout    (stat_timeout),
    .stat_discard    (stat_discard)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int underflow = 0;

  logic [7:0]  fifo_q [$];
  logic [7:0]  frame_q [$];
  logic [7:0]  exp_status, exp_cmd;
  logic [31:0] exp_addr;
  int          exp_count;
  logic [7:0]  exp_data [0:63];

  task automatic refresh();
    rx_fifo_empty = (fifo_q.size() == 0);
    rx_fifo_data  = rx_fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  // FWFT FIFO model: a pop strobe seen at the edge removes the head byte shortly after.
  bit do_pop;
  always @(posedge clk) begin
    do_pop = rx_fifo_rd_en;
    #1;
    if (do_pop) begin
      if (fifo_q.size() == 0) underflow++;
      else fifo_q.delete(0);
    end
    refresh();
  end

  task automatic push_frame();
    foreach (frame_q[i]) fifo_q.push_back(frame_q[i]);
    refresh();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    frame_consumed = 1'b0;
    fifo_q.delete();
    refresh();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic consume();
    @(negedge clk) frame_consumed = 1'b1;
    @(negedge clk) frame_consumed = 1'b0;
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      got = frame_valid;
    end
  endtask

  task automatic wait_fifo_empty(output bit ok);
    ok = (fifo_q.size() == 0);
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = (fifo_q.size() == 0);
    end
  endtask

  // CRC-8 as remainder of (message * x^8) mod (x^8 + x^2 + x + 1), bits MSB first.
  function automatic logic [7:0] crc_over(input int first, input int last);
    logic [8:0] r;
    r = '0;
    for (int i = first; i <= last + 1; i++) begin
      for (int b = 7; b >= 0; b--) begin
        r = {r[7:0], (i <= last) ? frame_q[i][b] : 1'b0};
        if (r[8]) r = r ^ 9'h107;
      end
    end
    return r[7:0];
  endfunction

  function automatic int payload_len(input logic [7:0] cmd);
    if (cmd[7]) return 0;
    return (int'(cmd[3:0]) + 1) * (1 << cmd[5:4]);
  endfunction

  task automatic start_frame(input logic [7:0] cmd, input logic [31:0] addr);
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(cmd);
    for (int i = 0; i < 4; i++) frame_q.push_back(addr[8*i +: 8]);
  endtask

  task automatic append_crc(input logic [7:0] flip);
    frame_q.push_back(crc_over(1, frame_q.size() - 1) ^ flip);
  endtask

  // Reference decode of one complete frame held in frame_q (index 0 is SOF).
  task automatic model_frame();
    int n;
    exp_cmd   = frame_q[1];
    exp_addr  = {frame_q[5], frame_q[4], frame_q[3], frame_q[2]};
    exp_count = 0;
    if (exp_cmd[5:4] == 2'b11) begin
      exp_status = 8'h02;
      return;
    end
    n = payload_len(exp_cmd);
    for (int i = 0; i < n; i++) exp_data[i] = frame_q[6 + i];
    if (frame_q[6 + n] == crc_over(1, 5 + n)) begin
      exp_status = 8'h00;
      exp_count  = n;
    end else begin
      exp_status = 8'h01;
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++) if (frame_data[i] !== 8'h00) bad++;
    n_checks++; if (frame_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", frame_valid); else n_pass++;
    n_checks++; if (frame_status !== 8'h00) $display("FAIL reset_status: got %h want 00", frame_status); else n_pass++;
    n_checks++; if (frame_cmd !== 8'h00) $display("FAIL reset_cmd: got %h want 00", frame_cmd); else n_pass++;
    n_checks++; if (frame_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", frame_addr); else n_pass++;
    n_checks++; if (frame_data_count !== 7'd0) $display("FAIL reset_count: got %0d want 0", frame_data_count); else n_pass++;
    n_checks++; if (parser_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", parser_busy); else n_pass++;
    n_checks++; if (rx_fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", rx_fifo_rd_en); else n_pass++;
    n_checks++; if (bad != 0) $display("FAIL reset_data: %0d nonzero bytes, want 0", bad); else n_pass++;
    n_checks++;
    if ({stat_frames_ok, stat_crc_err, stat_timeout, stat_discard} !== 64'h0)
      $display("FAIL reset_stats: got %h want 0", {stat_frames_ok, stat_crc_err, stat_timeout, stat_discard});
    else n_pass++;
  endtask

  task automatic test_read_frame();
    bit seen;
    int bad;
    frame_q = '{8'hA5, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h97, 8'h00};
    push_frame();
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = (fifo_q.size() == 1);
    end
    n_checks++; if (!seen || frame_valid !== 1'b1) $display("FAIL read_latency: valid %b after CRC pop, want 1", frame_valid); else n_pass++;
    n_checks++; if (frame_status !== 8'h00) $display("FAIL read_status: got %h want 00", frame_status); else n_pass++;
    n_checks++; if (frame_cmd !== 8'h80) $display("FAIL read_cmd: got %h want 80", frame_cmd); else n_pass++;
    n_checks++; if (frame_addr !== 32'h0) $display("FAIL read_addr: got %h want 0", frame_addr); else n_pass++;
    n_checks++; if (frame_data_count !== 7'd0) $display("FAIL read_count: got %0d want 0", frame_data_count); else n_pass++;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (frame_valid !== 1'b1 || rx_fifo_rd_en !== 1'b0 || frame_status !== 8'h00 ||
          frame_cmd !== 8'h80 || fifo_q.size() != 1) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL read_hold: %0d unstable cycles, want 0", bad); else n_pass++;
    consume();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_word_write(input logic [7:0] flip);
    bit got;
    int bad;
    logic [7:0] pay [4];
    pay = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    start_frame(8'h20, 32'h4000_0010);
    for (int i = 0; i < 4; i++) frame_q.push_back(pay[i]);
    append_crc(flip);
    push_frame();
    wait_valid(got);
    bad = 0;
    for (int i = 0; i < 4; i++) if (frame_data[i] !== pay[i]) bad++;
    n_checks++; if (!got) $display("FAIL write_valid(flip=%h): got 0 want 1", flip); else n_pass++;
    n_checks++;
    if (frame_status !== ((flip == 8'h00) ? 8'h00 : 8'h01))
      $display("FAIL write_status(flip=%h): got %h want %h", flip, frame_status, (flip == 8'h00) ? 8'h00 : 8'h01);
    else n_pass++;
    n_checks++; if (frame_addr !== 32'h4000_0010) $display("FAIL write_addr: got %h want 40000010", frame_addr); else n_pass++;
    n_checks++;
    if (frame_data_count !== ((flip == 8'h00) ? 7'd4 : 7'd0))
      $display("FAIL write_count(flip=%h): got %0d want %0d", flip, frame_data_count, (flip == 8'h00) ? 4 : 0);
    else n_pass++;
    n_checks++; if (bad != 0) $display("FAIL write_data: %0d wrong bytes, want 0", bad); else n_pass++;
    consume();
  endtask

  task automatic test_crc_error();
    bit got;
    logic [31:0] a;
    test_word_write(8'h01);
    a = $urandom;
    start_frame(8'h80, a);
    append_crc(8'h00);
    push_frame();
    wait_valid(got);
    n_checks++;
    if (!got || frame_status !== 8'h00 || frame_addr !== a)
      $display("FAIL crc_recover: valid %b status %h addr %h, want 1 00 %h", got, frame_status, frame_addr, a);
    else n_pass++;
    consume();
  endtask

  task automatic test_garbage();
    bit got;
    logic [31:0] a;
    apply_reset();
    frame_q = '{8'h00, 8'hFF, 8'h5A};
    push_frame();
    a = $urandom;
    start_frame(8'h80, a);
    append_crc(8'h00);
    push_frame();
    wait_valid(got);
    n_checks++;
    if (!got || frame_status !== 8'h00 || frame_addr !== a)
      $display("FAIL garbage_frame: valid %b status %h addr %h, want 1 00 %h", got, frame_status, frame_addr, a);
    else n_pass++;
    n_checks++;
    if (stat_discard !== (STATS ? 16'd3 : 16'd0)) $display("FAIL garbage_discard: got %0d want %0d", stat_discard, STATS ? 3 : 0);
    else n_pass++;
    n_checks++;
    if (stat_frames_ok !== (STATS ? 16'd1 : 16'd0)) $display("FAIL garbage_ok_count: got %0d want %0d", stat_frames_ok, STATS ? 1 : 0);
    else n_pass++;
    consume();
  endtask

  task automatic test_bad_cmd();
    bit got;
    frame_q = '{8'hA5, 8'h30, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                8'hA5, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h97};
    push_frame();
    wait_valid(got);
    n_checks++; if (!got || frame_status !== 8'h02) $display("FAIL badcmd_status: valid %b status %h want 1 02", got, frame_status); else n_pass++;
    n_checks++; if (frame_cmd !== 8'h30) $display("FAIL badcmd_cmd: got %h want 30", frame_cmd); else n_pass++;
    n_checks++; if (fifo_q.size() != 12) $display("FAIL badcmd_early: %0d bytes left want 12", fifo_q.size()); else n_pass++;
    consume();
    wait_valid(got);
    n_checks++;
    if (!got || frame_status !== 8'h00 || frame_cmd !== 8'h80)
      $display("FAIL badcmd_resync: valid %b status %h cmd %h, want 1 00 80", got, frame_status, frame_cmd);
    else n_pass++;
    consume();
  endtask

  task automatic test_timeout();
    bit ok, got;
    frame_q = '{8'hA5, 8'h80, 8'h00};
    push_frame();
    wait_fifo_empty(ok);
    repeat (TIMEOUT - 10) @(negedge clk);
    n_checks++;
    if (!ok || frame_valid !== 1'b0 || parser_busy !== 1'b1)
      $display("FAIL timeout_early: valid %b busy %b, want 0 1", frame_valid, parser_busy);
    else n_pass++;
    wait_valid(got);
    n_checks++; if (!got || frame_status !== 8'h03) $display("FAIL timeout_status: valid %b status %h want 1 03", got, frame_status); else n_pass++;
    n_checks++; if (frame_data_count !== 7'd0) $display("FAIL timeout_count: got %0d want 0", frame_data_count); else n_pass++;
    consume();
  endtask

  task automatic test_reset_mid_frame();
    bit ok, got;
    start_frame(8'h23, $urandom);
    for (int i = 0; i < 5; i++) frame_q.push_back(8'($urandom));
    push_frame();
    wait_fifo_empty(ok);
    @(negedge clk);
    n_checks++; if (!ok || parser_busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", parser_busy); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (frame_valid !== 1'b0 || parser_busy !== 1'b0 || frame_data_count !== 7'd0)
      $display("FAIL midrst_idle: valid %b busy %b count %0d, want 0 0 0", frame_valid, parser_busy, frame_data_count);
    else n_pass++;
    frame_q = '{8'hA5, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h97};
    push_frame();
    wait_valid(got);
    n_checks++; if (!got || frame_status !== 8'h00) $display("FAIL midrst_next: valid %b status %h want 1 00", got, frame_status); else n_pass++;
    consume();
  endtask

  task automatic test_back_to_back();
    bit got;
    logic [7:0]  a_status;
    logic [31:0] a_addr;
    int          a_count;
    start_frame(8'h11, $urandom);
    for (int i = 0; i < payload_len(8'h11); i++) frame_q.push_back(8'($urandom));
    append_crc(8'h00);
    model_frame();
    a_status = exp_status; a_addr = exp_addr; a_count = exp_count;
    push_frame();
    start_frame(8'h85, $urandom);
    append_crc(8'h00);
    model_frame();
    push_frame();
    wait_valid(got);
    n_checks++;
    if (!got || frame_status !== a_status || frame_addr !== a_addr || frame_data_count !== 7'(a_count))
      $display("FAIL b2b_first: status %h addr %h count %0d, want %h %h %0d", frame_status, frame_addr, frame_data_count, a_status, a_addr, a_count);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rx_fifo_rd_en !== 1'b0 || fifo_q.size() != 7)
      $display("FAIL b2b_hold: rd_en %b fifo %0d, want 0 7", rx_fifo_rd_en, fifo_q.size());
    else n_pass++;
    consume();
    wait_valid(got);
    n_checks++;
    if (!got || frame_status !== exp_status || frame_addr !== exp_addr || frame_cmd !== 8'h85)
      $display("FAIL b2b_second: status %h addr %h cmd %h, want %h %h 85", frame_status, frame_addr, frame_cmd, exp_status, exp_addr);
    else n_pass++;
    consume();
  endtask

  task automatic test_random();
    bit got;
    int bad, n_ok, n_err;
    logic [7:0] cmd, flip;
    apply_reset();
    n_ok = 0; n_err = 0;
    for (int f = 0; f < 30; f++) begin
      cmd  = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
      flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      start_frame(cmd, $urandom);
      for (int i = 0; i < payload_len(cmd); i++) frame_q.push_back(8'($urandom));
      append_crc(flip);
      model_frame();
      if (exp_status == 8'h00) n_ok++; else n_err++;
      push_frame();
      wait_valid(got);
      bad = 0;
      for (int i = 0; i < exp_count; i++) if (frame_data[i] !== exp_data[i]) bad++;
      n_checks++;
      if (!got || frame_status !== exp_status || frame_cmd !== exp_cmd || frame_addr !== exp_addr)
        $display("FAIL rand%0d_hdr: valid %b status %h cmd %h addr %h, want 1 %h %h %h",
                 f, got, frame_status, frame_cmd, frame_addr, exp_status, exp_cmd, exp_addr);
      else n_pass++;
      n_checks++;
      if (frame_data_count !== 7'(exp_count) || bad != 0)
        $display("FAIL rand%0d_data: count %0d bad %0d, want %0d 0", f, frame_data_count, bad, exp_count);
      else n_pass++;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      consume();
    end
    n_checks++;
    if (stat_frames_ok !== (STATS ? 16'(n_ok) : 16'd0) || stat_crc_err !== (STATS ? 16'(n_err) : 16'd0))
      $display("FAIL rand_stats: ok %0d crc %0d, want %0d %0d", stat_frames_ok, stat_crc_err, STATS ? n_ok : 0, STATS ? n_err : 0);
    else n_pass++;
  endtask

  initial begin
    refresh();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_read_frame();
    test_word_write(8'h00);
    test_crc_error();
    test_garbage();
    test_bad_cmd();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    n_checks++; if (underflow != 0) $display("FAIL pop_when_empty: got %0d want 0", underflow); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
